i4001_rom_ctrl: RTL

Bus-side controller for one 4001-style ROM chip on the MCS-4 4-bit bus. It follows the CPU's 8-phase instruction cycle using `sync`, and captures the 12-bit fetch address over A1-A3. On a chip match it reads one byte from a 1-cycle synchronous backing memory (BRAM on PYNQ) and drives it back nibble-wise in M1/M2. It also tracks SRC chip selection and serves the WRR/RDR I/O port instructions.

---
 rtl/i4001_rom_ctrl_if.sv | 42 ++++
 rtl/i4001_rom_ctrl.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/i4001_rom_ctrl_if.sv
// ----------------------------------------------------------------------------
// i4001_rom_ctrl_if
// Bundles the MCS-4 bus, backing-memory and I/O-port signals of one 4001-style
// ROM controller.
//   sync      - X3 marker from the CPU (next clk is A1)
//   cm_rom    - CPU command line to ROMs
//   dbus_in   - resolved 4-bit data bus
//   dbus_out  - value this ROM drives onto the bus
//   dbus_oe   - bus drive enable
//   mem_en    - backing memory read strobe (A3)
//   mem_addr  - backing memory byte address
//   mem_rdata - memory data, valid one clk after mem_en
//   io_in     - I/O port input pins
//   io_out    - I/O port output latch
//   io_we     - one-clk pulse when io_out is written
//   sync_err  - one-clk pulse on a sync protocol violation
// Modports: slave = the ROM controller, master = CPU/bus/memory side.
// ----------------------------------------------------------------------------
interface i4001_rom_ctrl_if;
    logic       sync;
    logic       cm_rom;
    logic [3:0] dbus_in;
    logic [3:0] dbus_out;
    logic       dbus_oe;
    logic       mem_en;
    logic [7:0] mem_addr;
    logic [7:0] mem_rdata;
    logic [3:0] io_in;
    logic [3:0] io_out;
    logic       io_we;
    logic       sync_err;

    modport slave (
        input  sync, cm_rom, dbus_in, mem_rdata, io_in,
        output dbus_out, dbus_oe, mem_en, mem_addr, io_out, io_we, sync_err
    );

    modport master (
        output sync, cm_rom, dbus_in, mem_rdata, io_in,
        input  dbus_out, dbus_oe, mem_en, mem_addr, io_out, io_we, sync_err
    );
endinterface

// File: rtl/i4001_rom_ctrl.sv
// ----------------------------------------------------------------------------
// i4001_rom_ctrl
// Bus-side controller for one 4001-style ROM on the MCS-4 bus. Tracks the
// 8-phase instruction cycle from sync, captures the fetch address over A1-A3,
// reads a byte from a 1-cycle synchronous memory on a chip match and returns
// it nibble-wise in M1/M2. Also tracks SRC chip selection and serves WRR/RDR.
// Ports:
//   clk  - clock, one bus phase per clk
//   rst  - synchronous active-high reset
//   bus  - i4001_rom_ctrl_if.slave (bus, memory and I/O port signals)
// Parameter:
//   CHIP_ID - chip number matched against address [11:8] and SRC operand
// ----------------------------------------------------------------------------
module i4001_rom_ctrl #(
    parameter logic [3:0] CHIP_ID = 4'h0
) (
    input  logic                    clk,
    input  logic                    rst,
    i4001_rom_ctrl_if.slave         bus
);

    localparam logic [3:0] PH_UNSYNC = 4'd0;
    localparam logic [3:0] PH_A1     = 4'd1;
    localparam logic [3:0] PH_A2     = 4'd2;
    localparam logic [3:0] PH_A3     = 4'd3;
    localparam logic [3:0] PH_M1     = 4'd4;
    localparam logic [3:0] PH_M2     = 4'd5;
    localparam logic [3:0] PH_X1     = 4'd6;
    localparam logic [3:0] PH_X2     = 4'd7;
    localparam logic [3:0] PH_X3     = 4'd8;

    logic [3:0] r_phase;
    logic [3:0] w_phase_nxt;
    logic [7:0] r_addr;
    logic       r_hit;
    // Only the low nibble of the fetched byte is needed after M1.
    logic [3:0] r_opbuf;
    logic [7:0] r_instr;
    logic       r_second;
    logic       r_io_cmd;
    logic       r_selected;
    logic [3:0] r_io_out;
    logic       r_io_we;
    logic       r_sync_err;

    logic       w_chip_match;
    logic       w_in_cycle;
    logic       w_two_word;
    logic       w_src;
    logic       w_wrr;
    logic       w_rdr;

    assign w_chip_match = (bus.dbus_in == CHIP_ID);
    assign w_in_cycle   = (r_phase >= PH_A1) && (r_phase <= PH_X2);

    // First words of the two-word instructions: JCN, FIM, JUN, JMS, ISZ.
    assign w_two_word = (r_instr[7:4] == 4'h1) ||
                        ((r_instr[7:4] == 4'h2) && !r_instr[0]) ||
                        (r_instr[7:4] == 4'h4) ||
                        (r_instr[7:4] == 4'h5) ||
                        (r_instr[7:4] == 4'h7);

    // A second word is pure data, so every decode is gated by r_second.
    assign w_src = !r_second && (r_instr[7:4] == 4'h2) && r_instr[0];
    assign w_wrr = !r_second && r_io_cmd && r_selected && (r_instr == 8'hE2);
    assign w_rdr = !r_second && r_io_cmd && r_selected && (r_instr == 8'hEA);

    always_comb begin
        w_phase_nxt = PH_UNSYNC;
        if (bus.sync) begin
            w_phase_nxt = PH_A1;
        end else begin
            case (r_phase)
                PH_A1:   w_phase_nxt = PH_A2;
                PH_A2:   w_phase_nxt = PH_A3;
                PH_A3:   w_phase_nxt = PH_M1;
                PH_M1:   w_phase_nxt = PH_M2;
                PH_M2:   w_phase_nxt = PH_X1;
                PH_X1:   w_phase_nxt = PH_X2;
                PH_X2:   w_phase_nxt = PH_X3;
                default: w_phase_nxt = PH_UNSYNC;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_phase    <= PH_UNSYNC;
            r_addr     <= 8'h00;
            r_hit      <= 1'b0;
            r_opbuf    <= 4'h0;
            r_instr    <= 8'h00;
            r_second   <= 1'b0;
            r_io_cmd   <= 1'b0;
            r_selected <= 1'b0;
            r_io_out   <= 4'h0;
            r_io_we    <= 1'b0;
            r_sync_err <= 1'b0;
        end else begin
            r_phase    <= w_phase_nxt;
            // Early sync inside a cycle, or a missing sync at X3.
            r_sync_err <= (bus.sync && w_in_cycle) || (!bus.sync && (r_phase == PH_X3));
            r_io_we    <= 1'b0;
            case (r_phase)
                PH_A1: r_addr[3:0] <= bus.dbus_in;
                PH_A2: r_addr[7:4] <= bus.dbus_in;
                PH_A3: r_hit <= w_chip_match;
                PH_M1: begin
                    r_instr[7:4] <= bus.dbus_in;
                    if (r_hit) begin
                        r_opbuf <= bus.mem_rdata[3:0];
                    end
                end
                PH_M2: begin
                    r_instr[3:0] <= bus.dbus_in;
                    r_io_cmd     <= bus.cm_rom;
                end
                PH_X2: begin
                    if (w_src && bus.cm_rom) begin
                        r_selected <= w_chip_match;
                    end
                    if (w_wrr) begin
                        r_io_out <= bus.dbus_in;
                        r_io_we  <= 1'b1;
                    end
                end
                PH_X3: r_second <= !r_second && w_two_word;
                default: ;
            endcase
        end
    end

    // Drive is decoded from the current phase, so a resync or reset drops it
    // on the very next edge.
    always_comb begin
        bus.dbus_out = 4'h0;
        bus.dbus_oe  = 1'b0;
        case (r_phase)
            PH_M1: begin
                if (r_hit) begin
                    bus.dbus_out = bus.mem_rdata[7:4];
                    bus.dbus_oe  = 1'b1;
                end
            end
            PH_M2: begin
                if (r_hit) begin
                    bus.dbus_out = r_opbuf;
                    bus.dbus_oe  = 1'b1;
                end
            end
            PH_X2: begin
                if (w_rdr) begin
                    bus.dbus_out = bus.io_in;
                    bus.dbus_oe  = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign bus.mem_en   = (r_phase == PH_A3) && w_chip_match;
    assign bus.mem_addr = r_addr;
    assign bus.io_out   = r_io_out;
    assign bus.io_we    = r_io_we;
    assign bus.sync_err = r_sync_err;

endmodule
